// File: rtl/l2_line_adapter_if.sv
// Signal bundle for l2_line_adapter: the L1-side 512-bit line port and the
// L2-side 128-bit beat port. The adapter uses the slave view; the
// surrounding logic (or a testbench) uses the master view.
interface l2_line_adapter_if #(
    parameter int LINE_ADDR_BITS = 12,
    parameter int TAG_BITS       = 5
);
    // L1 line request
    logic                      line_req_val;
    logic                      line_req_rdy;
    logic                      line_req_rw;
    logic [LINE_ADDR_BITS-1:0] line_req_addr;
    logic [511:0]              line_req_data;
    logic [TAG_BITS-1:0]       line_req_tag;

    // L1 line response (reads only)
    logic                      line_resp_val;
    logic [511:0]              line_resp_data;
    logic [TAG_BITS-1:0]       line_resp_tag;

    // L2 beat request
    logic                      mem_req_val;
    logic                      mem_req_rdy;
    logic [1:0]                mem_req_rw;
    logic [LINE_ADDR_BITS+1:0] mem_req_addr;
    logic [127:0]              mem_req_data;
    logic [TAG_BITS-1:0]       mem_req_tag;

    // L2 beat response
    logic                      mem_resp_val;
    logic                      mem_resp_nack;
    logic [127:0]              mem_resp_data;
    logic [TAG_BITS-1:0]       mem_resp_tag;

    // Adapter side
    modport slave (
        input  line_req_val, line_req_rw, line_req_addr, line_req_data, line_req_tag,
        output line_req_rdy,
        output line_resp_val, line_resp_data, line_resp_tag,
        output mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
        input  mem_req_rdy,
        input  mem_resp_val, mem_resp_nack, mem_resp_data, mem_resp_tag
    );

    // Requester / L2 side
    modport master (
        output line_req_val, line_req_rw, line_req_addr, line_req_data, line_req_tag,
        input  line_req_rdy,
        input  line_resp_val, line_resp_data, line_resp_tag,
        input  mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
        output mem_req_rdy,
        output mem_resp_val, mem_resp_nack, mem_resp_data, mem_resp_tag
    );
endinterface

// File: rtl/l2_line_adapter.sv
// Splits 512-bit L1 line writes into four 128-bit L2 store beats, issues a
// single 4-beat L2 load for line reads and reassembles the returned beats
// into one line response. One line operation is in flight at a time; every
// output toward the L2 and the L1 response port comes straight from a flop.
module l2_line_adapter #(
    parameter int LINE_ADDR_BITS = 12,
    parameter int TAG_BITS       = 5
) (
    input  logic             clk,
    input  logic             reset,
    l2_line_adapter_if.slave bus
);
    localparam int BEAT_ADDR_BITS = LINE_ADDR_BITS + 2;

    localparam logic [1:0] RW_LOAD  = 2'b00;
    localparam logic [1:0] RW_STORE = 2'b01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_REQ  = 2'd2,
        RD_WAIT = 2'd3
    } state_e;

    // Control state
    state_e                    state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;

    // Held line operation (no reset needed: only read while busy)
    logic [LINE_ADDR_BITS-1:0] line_q, line_d;
    logic [511:0]              wdata_q, wdata_d;
    logic [TAG_BITS-1:0]       tag_q, tag_d;
    logic [511:0]              rbuf_q, rbuf_d;

    // Registered L2 request outputs
    logic                      req_val_q, req_val_d;
    logic [1:0]                req_rw_q, req_rw_d;
    logic [BEAT_ADDR_BITS-1:0] req_addr_q, req_addr_d;
    logic [127:0]              req_data_q, req_data_d;
    logic [TAG_BITS-1:0]       req_tag_q, req_tag_d;

    // Registered line response outputs
    logic                      resp_val_q, resp_val_d;
    logic [511:0]              resp_data_q, resp_data_d;
    logic [TAG_BITS-1:0]       resp_tag_q, resp_tag_d;

    logic                      req_hs;
    logic                      resp_hit;
    logic [1:0]                cnt_inc;

    // Beat k of a line lives at bits [128k+127:128k].
    function automatic logic [127:0] beat_of(input logic [511:0] line, input logic [1:0] idx);
        return line[{idx, 7'd0} +: 128];
    endfunction

    assign req_hs   = req_val_q & bus.mem_req_rdy;
    assign resp_hit = bus.mem_resp_val & (bus.mem_resp_tag == tag_q);
    assign cnt_inc  = cnt_q + 2'd1;

    // Next-state and next-output logic for the line sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        wdata_d     = wdata_q;
        tag_d       = tag_q;
        rbuf_d      = rbuf_q;
        req_val_d   = req_val_q;
        req_rw_d    = req_rw_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_tag_d   = req_tag_q;
        resp_val_d  = 1'b0;
        resp_data_d = resp_data_q;
        resp_tag_d  = resp_tag_q;

        unique case (state_q)
            IDLE: begin
                if (bus.line_req_val) begin
                    line_d     = bus.line_req_addr;
                    wdata_d    = bus.line_req_data;
                    tag_d      = bus.line_req_tag;
                    cnt_d      = 2'd0;
                    req_val_d  = 1'b1;
                    req_addr_d = {bus.line_req_addr, 2'b00};
                    req_tag_d  = bus.line_req_tag;
                    if (bus.line_req_rw) begin
                        state_d    = WR;
                        req_rw_d   = RW_STORE;
                        req_data_d = beat_of(bus.line_req_data, 2'd0);
                    end else begin
                        state_d    = RD_REQ;
                        req_rw_d   = RW_LOAD;
                        req_data_d = '0;
                    end
                end
            end

            WR: begin
                // Present beat stays put until the L2 takes it.
                if (req_hs) begin
                    if (cnt_q == 2'd3) begin
                        state_d   = IDLE;
                        cnt_d     = 2'd0;
                        req_val_d = 1'b0;
                    end else begin
                        cnt_d      = cnt_inc;
                        req_addr_d = {line_q, cnt_inc};
                        req_data_d = beat_of(wdata_q, cnt_inc);
                    end
                end
            end

            RD_REQ: begin
                if (req_hs) begin
                    state_d   = RD_WAIT;
                    cnt_d     = 2'd0;
                    req_val_d = 1'b0;
                end
            end

            RD_WAIT: begin
                // Beats carrying some other tag belong to someone else.
                if (resp_hit) begin
                    if (bus.mem_resp_nack) begin
                        // Throw away partial line and re-issue the load.
                        state_d    = RD_REQ;
                        cnt_d      = 2'd0;
                        req_val_d  = 1'b1;
                        req_rw_d   = RW_LOAD;
                        req_addr_d = {line_q, 2'b00};
                        req_tag_d  = tag_q;
                        req_data_d = '0;
                    end else begin
                        rbuf_d[{cnt_q, 7'd0} +: 128] = bus.mem_resp_data;
                        if (cnt_q == 2'd3) begin
                            state_d     = IDLE;
                            cnt_d       = 2'd0;
                            resp_val_d  = 1'b1;
                            resp_data_d = rbuf_d;
                            resp_tag_d  = tag_q;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = 2'd0;
                req_val_d = 1'b0;
            end
        endcase
    end

    // Control and output registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            req_val_q   <= 1'b0;
            req_rw_q    <= 2'b00;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_tag_q   <= '0;
            resp_val_q  <= 1'b0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_val_q   <= req_val_d;
            req_rw_q    <= req_rw_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_tag_q   <= req_tag_d;
            resp_val_q  <= resp_val_d;
            resp_data_q <= resp_data_d;
            resp_tag_q  <= resp_tag_d;
        end
    end

    // Operation holding registers and read reassembly buffer
    always_ff @(posedge clk) begin
        line_q  <= line_d;
        wdata_q <= wdata_d;
        tag_q   <= tag_d;
        rbuf_q  <= rbuf_d;
    end

    assign bus.line_req_rdy   = (state_q == IDLE);
    assign bus.mem_req_val    = req_val_q;
    assign bus.mem_req_rw     = req_rw_q;
    assign bus.mem_req_addr   = req_addr_q;
    assign bus.mem_req_data   = req_data_q;
    assign bus.mem_req_tag    = req_tag_q;
    assign bus.line_resp_val  = resp_val_q;
    assign bus.line_resp_data = resp_data_q;
    assign bus.line_resp_tag  = resp_tag_q;
endmodule
